// File: rtl/jk_sync_counter.sv
// Modulo-MODULUS up/down counter built from a bank of JK state bits.
// Count, load and reset are all turned into per-bit J/K drives through one equation.
module jk_sync_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             wrap,
    output logic             err
);

    if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
        $error("jk_sync_counter: MODULUS out of range for WIDTH");
    end

    localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qbar_q;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] j, k;
    logic             din_ok;
    logic             at_end;

    assign din_ok   = {1'b0, din} < MOD_EXT;
    assign load_val = din_ok ? din : '0;
    assign at_end   = up ? (q_q == MAXV) : (q_q == '0);

    always_comb begin
        cnt_next = q_q;
        if (up) cnt_next = (q_q == MAXV) ? '0 : q_q + WIDTH'(1);
        else    cnt_next = (q_q == '0) ? MAXV : q_q - WIDTH'(1);
    end

    // Reset and load become direct set/clear drives (J=v, K=~v); counting toggles changed bits.
    always_comb begin
        j      = '0;
        k      = '0;
        wrap_d = 1'b0;
        err_d  = err_q;
        if (!rst) begin
            j     = '0;
            k     = '1;
            err_d = 1'b0;
        end else if (load) begin
            j     = load_val;
            k     = ~load_val;
            err_d = err_q | ~din_ok;
        end else if (en) begin
            j      = q_q ^ cnt_next;
            k      = q_q ^ cnt_next;
            wrap_d = at_end;
        end
        q_d = (j & ~q_q) | (~k & q_q);
    end

    always_ff @(posedge clk) begin
        q_q    <= q_d;
        qbar_q <= ~q_d;
        wrap_q <= wrap_d;
        err_q  <= err_d;
    end

    assign q    = q_q;
    assign qbar = qbar_q;
    assign wrap = wrap_q;
    assign err  = err_q;
    assign tc   = en & ~load & at_end;

endmodule
